uart_rx_capture: RTL
====================

UART_RX_CAPTURE -- requirements
Module: uart_rx_capture

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 32, giving clk cycles per UART bit (25 MHz / 781250 baud); legal range 8..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the captured-byte buffer depth; legal values are powers of two from 2 to 64.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_i  input  1  serial line driven by the DUT uart_tx pad, 8N1, idle high, asynchronous to clk.
REQ-006 rx_en_i  input  1  enables detection of new start bits.
REQ-007 data_o  output  8  head byte of FIFO.
REQ-008 valid_o  output  1  FIFO non-empty.
REQ-009 ready_i  input  1  consumer accepts head byte when valid_o && ready_i.
REQ-010 frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-011 overflow_o  output  1  sticky; a completed byte was dropped because the FIFO was full.
REQ-012 newline_o  output  1  one-cycle pulse when byte 8'h0A is written into the FIFO.
REQ-013 byte_cnt_o  output  16  count of bytes written into the FIFO, wraps 16'hFFFF -> 0.

Function
REQ-014 rx_i SHALL pass through a 2-flop synchronizer reset to 1; only the synchronized value (rxs) is used.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP; reset state IDLE.
REQ-016 IDLE -> START when rx_en_i=1 and rxs falls 1->0 (previous rxs=1, current rxs=0); a low line at reset exit SHALL NOT start a frame.
REQ-017 START: the bit counter SHALL run CLKS_PER_BIT/2 cycles (integer division); rxs=0 at terminal count -> DATA, rxs=1 -> IDLE (glitch; no error, no push).
REQ-018 DATA: rxs SHALL be sampled every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first; after the 8th sample -> STOP.
REQ-019 STOP: rxs SHALL be sampled CLKS_PER_BIT cycles after the 8th data sample; rxs=1 -> push byte, rxs=0 -> pulse frame_err_o and discard byte; both cases -> IDLE.
REQ-020 Deasserting rx_en_i mid-frame SHALL NOT abort the frame; it gates only REQ-016.
REQ-021 Push SHALL occur in the stop-sample cycle; valid_o SHALL rise the following cycle (no fall-through).
REQ-022 Pop occurs when valid_o && ready_i; data_o SHALL hold stable while valid_o && !ready_i.
REQ-023 FIFO full with simultaneous push and pop: both SHALL occur; occupancy is unchanged; no overflow.
REQ-024 FIFO full with push and no pop: byte dropped, overflow_o set, byte_cnt_o and newline_o unchanged.
REQ-025 FIFO empty with push: byte written; pop not possible that cycle (valid_o=0).
REQ-026 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and remaining bits equal.
REQ-027 newline_o and byte_cnt_o increment SHALL occur in the same cycle as the successful push.

Reset
REQ-028 While rst=1, asynchronously: FSM=IDLE, FIFO empty, synchronizer=1, valid_o=0, data_o=8'h00, frame_err_o=0, overflow_o=0, newline_o=0, byte_cnt_o=0.
REQ-029 rst asserted mid-frame SHALL discard the partial byte; the next frame requires a fresh falling edge per REQ-016.
REQ-030 overflow_o SHALL clear only on rst.

Verification
REQ-031 Send 8'h65 at 32 clk/bit, ready_i=1 -> valid_o for 1 cycle with data_o=8'h65; byte_cnt_o=1; no error.
REQ-032 Send "OK\n" (8'h4F, 8'h4B, 8'h0A) with ready_i=0 -> 3 entries in order; newline_o pulses once, at the third push; byte_cnt_o=3.
REQ-033 Send 5 bytes, ready_i=0, FIFO_DEPTH=4 -> overflow_o=1 after the 5th stop sample; drain yields bytes 1..4; byte_cnt_o=4.
REQ-034 Stop bit forced 0 on byte 8'hA5 -> frame_err_o pulses one cycle; valid_o stays 0; byte_cnt_o=0.
REQ-035 Low pulse of 10 clk on idle line -> rejected as glitch at half-bit sample; no push, no error; then a valid 8'h3C is received correctly.
REQ-036 rst asserted during bit 4 of a frame, released 5 cycles later, then a valid 8'h11 is sent -> only 8'h11 is captured; all outputs equal reset values before it.

Source files
------------

// File: rtl/uart_rx_capture.sv
// uart_rx_capture
// Receives 8N1 serial bytes from a UART line and queues them in a small FIFO.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit (8..65535)
//   FIFO_DEPTH   - captured-byte buffer depth (power of two, 2..64)
//
// Ports:
//   clk          - clock, all state on rising edge
//   rst          - asynchronous active-high reset
//   rx_i         - serial line, idle high, asynchronous to clk
//   rx_en_i      - enables detection of new start bits
//   data_o       - head byte of the FIFO (8'h00 when empty)
//   valid_o      - FIFO non-empty
//   ready_i      - consumer pops head when valid_o && ready_i
//   frame_err_o  - one-cycle pulse when a stop bit samples low
//   overflow_o   - sticky: a completed byte was dropped on a full FIFO
//   newline_o    - one-cycle pulse when 8'h0A is written into the FIFO
//   byte_cnt_o   - bytes written into the FIFO, wraps at 16 bits
module uart_rx_capture #(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  input  logic        rx_en_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_err_o,
  output logic        overflow_o,
  output logic        newline_o,
  output logic [15:0] byte_cnt_o
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] HALF_TC = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_TC = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and falling-edge detect
  // ---------------------------------------------------------------------------
  logic       rx_meta_q;
  logic       rxs_q;
  logic       rxs_prev_q;
  logic [2:0] warm_q;
  logic       start_edge;

  // warm_q fills with ones after reset; rxs_prev_q only reflects the real line
  // once all three stages have loaded, so a line held low through reset exit
  // never looks like a 1->0 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      warm_q     <= '0;
    end else begin
      rx_meta_q  <= rx_i;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      warm_q     <= {warm_q[1:0], 1'b1};
    end
  end

  assign start_edge = rx_en_i && warm_q[2] && rxs_prev_q && !rxs_q;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_req;
  logic        frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line back high at mid-start is a glitch: drop it silently.
          state_d = rxs_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_TC) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs_q) begin
            push_req = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO (pointers carry one extra wrap bit)
  // ---------------------------------------------------------------------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic        drop;
  logic        overflow_q;
  logic [15:0] byte_cnt_q;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = !empty && ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q   <= wr_ptr_q + 1'b1;
        byte_cnt_q <= byte_cnt_q + 16'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign valid_o     = !empty;
  assign data_o      = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign frame_err_o = frame_err;
  assign overflow_o  = overflow_q;
  assign newline_o   = push_ok && (shift_q == 8'h0A);
  assign byte_cnt_o  = byte_cnt_q;

endmodule
